// File: rtl/nn_pkg.sv
// Shared definitions for the NN layer datapath: element type, serializer states, saturation limits.
package nn_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_t;

  localparam data_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/bias_act_unit.sv
// Combinational bias add with signed saturation followed by activation.
// BIAS_RELU_LEAKY_EN selects a leaky ReLU (arithmetic shift by LEAKY_SHIFT) instead of plain ReLU.
module bias_act_unit #(
  parameter int unsigned DATA_W = nn_pkg::DATA_W
`ifdef BIAS_RELU_LEAKY_EN
  ,
  parameter int unsigned LEAKY_SHIFT = 3
`endif
) (
  input  logic [DATA_W-1:0] element,
  input  logic [DATA_W-1:0] bias_val,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] clamped;

  always_comb begin
    sum = {element[DATA_W-1], element} + {bias_val[DATA_W-1], bias_val};
    // Overflow exactly when the two top bits of the extended sum disagree.
    sat = sum[DATA_W] ^ sum[DATA_W-1];
    if (!sat) begin
      clamped = sum[DATA_W-1:0];
    end else if (sum[DATA_W]) begin
      clamped = MIN_V;
    end else begin
      clamped = MAX_V;
    end
    if (clamped[DATA_W-1]) begin
`ifdef BIAS_RELU_LEAKY_EN
      result = clamped >>> LEAKY_SHIFT;
`else
      result = '0;
`endif
    end else begin
      result = clamped;
    end
  end

endmodule

// File: rtl/bias_relu_serializer.sv
// Captures an MxN matrix plus per-column bias, then streams bias+activation results in row-major order.
// Optional leaky activation via BIAS_RELU_LEAKY_EN (adds parameter LEAKY_SHIFT).
module bias_relu_serializer
  import nn_pkg::*;
#(
  parameter int unsigned M      = 2,
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 32,
`ifdef BIAS_RELU_LEAKY_EN
  parameter int unsigned LEAKY_SHIFT = 3,
`endif
  localparam int unsigned IDX_W = (M*N > 1) ? $clog2(M*N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [M*N*DATA_W-1:0]   in_matrix,
  input  logic [N*DATA_W-1:0]     bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    out_sat
);

  localparam int unsigned ELEMS = M*N;
  localparam int unsigned COL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS-1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N-1);

  ser_state_t state, state_nxt;

  logic [DATA_W-1:0] mat_buf  [ELEMS];
  logic [DATA_W-1:0] bias_buf [N];
  logic [COL_W-1:0]  out_col;
  logic [IDX_W-1:0]  nxt_idx;
  logic [COL_W-1:0]  nxt_col;
  logic [DATA_W-1:0] sel_elem, sel_bias, act_result;
  logic              act_sat;

  assign in_ready = (state == IDLE);
  assign nxt_idx  = (out_index == LAST_IDX) ? '0 : out_index + 1'b1;
  assign nxt_col  = (out_col == LAST_COL) ? '0 : out_col + 1'b1;

  // In IDLE the unit sees element 0 straight from the inputs so the first result
  // can be registered on the same edge that fills the buffers.
  always_comb begin
    if (state == IDLE) begin
      sel_elem = in_matrix[DATA_W-1:0];
      sel_bias = bias[DATA_W-1:0];
    end else begin
      sel_elem = mat_buf[nxt_idx];
      sel_bias = bias_buf[nxt_col];
    end
  end

  bias_act_unit #(
    .DATA_W(DATA_W)
`ifdef BIAS_RELU_LEAKY_EN
    ,
    .LEAKY_SHIFT(LEAKY_SHIFT)
`endif
  ) u_act (
    .element (sel_elem),
    .bias_val(sel_bias),
    .result  (act_result),
    .sat     (act_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = STREAM;
      STREAM:  if (out_ready && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      for (int unsigned i = 0; i < ELEMS; i++) mat_buf[i] <= '0;
      for (int unsigned j = 0; j < N; j++) bias_buf[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < ELEMS; i++) mat_buf[i] <= in_matrix[i*DATA_W +: DATA_W];
            for (int unsigned j = 0; j < N; j++) bias_buf[j] <= bias[j*DATA_W +: DATA_W];
            out_data  <= act_result;
            out_sat   <= act_sat;
            out_index <= '0;
            out_col   <= '0;
            out_last  <= (LAST_IDX == '0);
            out_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
            end else begin
              out_data  <= act_result;
              out_sat   <= act_sat;
              out_index <= nxt_idx;
              out_col   <= nxt_col;
              out_last  <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu_serializer.sv
// Self-checking bench for bias_relu_serializer (M=N=2); honours BIAS_RELU_LEAKY_EN with shift 3.
module tb_bias_relu_serializer;

  localparam int unsigned LS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_matrix;
  logic [63:0]   bias;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [1:0]    out_index;
  logic          out_last;
  logic          out_sat;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0][31:0] mat;
    logic [1:0][31:0] bs;
    logic [3:0][31:0] exp_d;
    logic [3:0]       exp_s;
  } vec_t;

  always #5 clk = ~clk;

  bias_relu_serializer #(
    .M(2),
    .N(2),
    .DATA_W(32)
`ifdef BIAS_RELU_LEAKY_EN
    ,
    .LEAKY_SHIFT(LS)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_matrix(in_matrix),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .out_sat  (out_sat)
  );

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: wide integer add, clamp to 32-bit signed range, then activation.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, output logic sat);
    longint s;
    s   = longint'($signed(a)) + longint'($signed(b));
    sat = 1'b0;
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647;
      sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648;
      sat = 1'b1;
    end
    if (s < 0) begin
`ifdef BIAS_RELU_LEAKY_EN
      s = s >>> LS;
`else
      s = 0;
`endif
    end
    return s[31:0];
  endfunction

  function automatic vec_t mkv(input logic [31:0] m0, m1, m2, m3, b0, b1, e0, e1, e2, e3,
                               input logic [3:0] s);
    vec_t v;
    v.mat[0] = m0; v.mat[1] = m1; v.mat[2] = m2; v.mat[3] = m3;
    v.bs[0]  = b0; v.bs[1]  = b1;
    v.exp_d[0] = e0; v.exp_d[1] = e1; v.exp_d[2] = e2; v.exp_d[3] = e3;
    v.exp_s = s;
    return v;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(3))
      0:       return $urandom;
      1:       return 32'h7FFFFFFF - $urandom_range(64);
      2:       return 32'h80000000 + $urandom_range(64);
      default: return $urandom_range(64) - 32;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input bit bp, input string tag);
    int got;
    int cyc;
    in_matrix = v.mat;
    bias      = v.bs;
    in_valid  = 1'b1;
    chk(tag, "in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk(tag, "first_valid", out_valid, 1);
    chk(tag, "in_ready_busy", in_ready, 0);
    in_matrix = {$urandom, $urandom, $urandom, $urandom};
    bias      = {$urandom, $urandom};
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 64) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      chk(tag, "valid", out_valid, 1);
      if (out_ready) begin
        chk(tag, "data", out_data, v.exp_d[got]);
        chk(tag, "index", out_index, got);
        chk(tag, "last", out_last, got == 3);
        chk(tag, "sat", out_sat, v.exp_s[got]);
        got++;
        tick();
      end else begin
        tick();
        chk(tag, "stall_data", out_data, v.exp_d[got]);
        chk(tag, "stall_index", out_index, got);
      end
      cyc++;
    end
    chk(tag, "elements", got, 4);
    if (!bp) chk(tag, "gapless_cycles", cyc, 4);
    out_ready = 1'b0;
    chk(tag, "valid_after_last", out_valid, 0);
    chk(tag, "in_ready_after_last", in_ready, 1);
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic s_bit;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_matrix = '0;
    bias      = '0;
    #12;
    chk("reset", "in_ready", in_ready, 1);
    chk("reset", "out_valid", out_valid, 0);
    chk("reset", "out_data", out_data, 0);
    chk("reset", "out_index", out_index, 0);
    chk("reset", "out_last", out_last, 0);
    chk("reset", "out_sat", out_sat, 0);
    tick();
    reset = 1'b0;
    tick();

`ifdef BIAS_RELU_LEAKY_EN
    tbl.push_back(mkv(3, 3, 2, 2, 1, 32'hFFFFFFFB, 4, 32'hFFFFFFFF, 3, 32'hFFFFFFFF, 4'b0000));
    tbl.push_back(mkv(32'h7FFFFFF0, 32'h80000000, 32'h10, 32'hFFFFFFF0, 32'h100, 32'hFFFFFFFF,
                      32'h7FFFFFFF, 32'hF0000000, 32'h110, 32'hFFFFFFFD, 4'b0011));
    tbl.push_back(mkv(5, 6, 7, 8, 0, 0, 5, 6, 7, 8, 4'b0000));
    tbl.push_back(mkv(32'h7FFFFFFF, 1, 32'h80000000, 32'h7FFFFFFF, 0, 32'h7FFFFFFF,
                      32'h7FFFFFFF, 32'h7FFFFFFF, 32'hF0000000, 32'h7FFFFFFF, 4'b1010));
    tbl.push_back(mkv(32'hFFFFFFF1, 8, 32'hFFFFFFFC, 0, 32'hFFFFFFFF, 0,
                      32'hFFFFFFFE, 8, 32'hFFFFFFFF, 0, 4'b0000));
`else
    tbl.push_back(mkv(3, 3, 2, 2, 1, 32'hFFFFFFFB, 4, 0, 3, 0, 4'b0000));
    tbl.push_back(mkv(32'h7FFFFFF0, 32'h80000000, 32'h10, 32'hFFFFFFF0, 32'h100, 32'hFFFFFFFF,
                      32'h7FFFFFFF, 0, 32'h110, 0, 4'b0011));
    tbl.push_back(mkv(5, 6, 7, 8, 0, 0, 5, 6, 7, 8, 4'b0000));
    tbl.push_back(mkv(32'h7FFFFFFF, 1, 32'h80000000, 32'h7FFFFFFF, 0, 32'h7FFFFFFF,
                      32'h7FFFFFFF, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 4'b1010));
`endif

    foreach (tbl[i]) begin
      run_vec(tbl[i], 1'b0, $sformatf("tbl%0d", i));
      tick();
    end
    run_vec(tbl[0], 1'b1, "backpressure");
    tick();

    // Reset after the second output handshake.
    in_matrix = tbl[0].mat;
    bias      = tbl[0].bs;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rst_mid", "data0", out_data, tbl[0].exp_d[0]);
    tick();
    chk("rst_mid", "data1", out_data, tbl[0].exp_d[1]);
    tick();
    chk("rst_mid", "index2", out_index, 2);
    out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid", "valid_async", out_valid, 0);
    chk("rst_mid", "last_async", out_last, 0);
    chk("rst_mid", "index_async", out_index, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid", "in_ready_after", in_ready, 1);
    chk("rst_mid", "valid_after", out_valid, 0);
    run_vec(tbl[2], 1'b0, "after_reset");
    tick();

    // in_valid held high across two matrices.
    in_matrix = tbl[0].mat;
    bias      = tbl[0].bs;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_matrix = tbl[2].mat;
    bias      = tbl[2].bs;
    for (int k = 0; k < 4; k++) begin
      chk("b2b", "a_data", out_data, tbl[0].exp_d[k]);
      chk("b2b", "a_index", out_index, k);
      tick();
    end
    chk("b2b", "gap_in_ready", in_ready, 1);
    chk("b2b", "gap_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("b2b", "second_capture", out_valid, 1);
    for (int k = 0; k < 4; k++) begin
      chk("b2b", "b_data", out_data, tbl[2].exp_d[k]);
      chk("b2b", "b_last", out_last, k == 3);
      tick();
    end
    out_ready = 1'b0;
    chk("b2b", "end_valid", out_valid, 0);
    tick();

    // Randomized matrices against the reference model.
    for (int t = 0; t < 16; t++) begin
      for (int e = 0; e < 4; e++) rv.mat[e] = rnd_val();
      for (int c = 0; c < 2; c++) rv.bs[c] = rnd_val();
      for (int e = 0; e < 4; e++) begin
        rv.exp_d[e] = model(rv.mat[e], rv.bs[e % 2], s_bit);
        rv.exp_s[e] = s_bit;
      end
      run_vec(rv, $urandom_range(1) == 1, $sformatf("rand%0d", t));
      if ($urandom_range(1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
